anabellek_hakem: RTL and testbench

Two-requester arbiter that shares the single main-memory (iomem) port between the instruction cache controller (L1B, read-only) and the data cache controller (L1V, read/write). It sits between both L1 controllers and the main memory controller. It grants the port one whole transaction at a time, using round-robin priority, and forces a one-cycle idle gap between transactions. A watchdog flags any transaction that waits too long for `iomem_ready_i`.

---
 rtl/anabellek_hakem.sv | 121 ++++++++++++
 tb/tb_anabellek_hakem.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/anabellek_hakem.sv
// anabellek_hakem: shares the single iomem port between the L1B (instruction,
// read-only) and L1V (data, read/write) cache controllers. Each grant covers
// one whole transaction. Priority is round-robin. Every transaction is
// followed by one idle cycle. A sticky watchdog flags grants that wait too
// long for iomem_ready_i.
//
// state  | meaning
// BOSTA  | idle, iomem port released, picks the next requester
// BUYRUK | L1B owns the port until iomem_ready_i
// VERI   | L1V owns the port until iomem_ready_i
module anabellek_hakem #(
    parameter bit          ONCELIK_BASLANGIC = 1'b0,
    parameter logic [15:0] BEKLEME_SINIRI    = 16'd1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [18:2] l1b_addr_i,
    input  logic        l1b_valid_i,
    output logic [31:0] l1b_rdata_o,
    output logic        l1b_ready_o,
    input  logic [18:2] l1v_addr_i,
    input  logic        l1v_valid_i,
    input  logic [31:0] l1v_wdata_i,
    input  logic [3:0]  l1v_wstrb_i,
    output logic [31:0] l1v_rdata_o,
    output logic        l1v_ready_o,
    output logic [18:2] iomem_addr_o,
    output logic        iomem_valid_o,
    output logic [31:0] iomem_wdata_o,
    output logic [3:0]  iomem_wstrb_o,
    input  logic [31:0] iomem_rdata_i,
    input  logic        iomem_ready_i,
    output logic        hata_o
);

    typedef enum logic [1:0] {
        BOSTA  = 2'd0,
        BUYRUK = 2'd1,
        VERI   = 2'd2
    } durum_t;

    durum_t      durum_r;
    logic        oncelik_r;   // 1: L1B wins a tie, 0: L1V wins a tie
    logic [15:0] sayac_r;
    logic        granted;

    assign granted = (durum_r == BUYRUK) || (durum_r == VERI);

    // Grant sequencing, round-robin priority update and the grant watchdog.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_r   <= BOSTA;
            oncelik_r <= ONCELIK_BASLANGIC;
            sayac_r   <= 16'd0;
            hata_o    <= 1'b0;
        end else begin
            case (durum_r)
                BOSTA: begin
                    if (l1b_valid_i && (!l1v_valid_i || oncelik_r)) begin
                        durum_r <= BUYRUK;
                        sayac_r <= 16'd0;
                    end else if (l1v_valid_i) begin
                        durum_r <= VERI;
                        sayac_r <= 16'd0;
                    end
                end
                BUYRUK: begin
                    if (iomem_ready_i) begin
                        durum_r   <= BOSTA;
                        oncelik_r <= 1'b0;
                    end
                end
                VERI: begin
                    if (iomem_ready_i) begin
                        durum_r   <= BOSTA;
                        oncelik_r <= 1'b1;
                    end
                end
                default: durum_r <= BOSTA;
            endcase

            // Counting only matters while granted; entry from BOSTA clears it.
            if (granted) begin
                if (!iomem_ready_i && (sayac_r != 16'hFFFF))
                    sayac_r <= sayac_r + 16'd1;
                if (sayac_r == BEKLEME_SINIRI)
                    hata_o <= 1'b1;
            end
        end
    end

    // Steer the iomem port to the granted requester; everything else reads 0.
    always_comb begin
        iomem_valid_o = 1'b0;
        iomem_addr_o  = '0;
        iomem_wdata_o = 32'd0;
        iomem_wstrb_o = 4'd0;
        l1b_ready_o   = 1'b0;
        l1b_rdata_o   = 32'd0;
        l1v_ready_o   = 1'b0;
        l1v_rdata_o   = 32'd0;
        case (durum_r)
            BUYRUK: begin
                iomem_valid_o = 1'b1;
                iomem_addr_o  = l1b_addr_i;
                l1b_ready_o   = iomem_ready_i;
                l1b_rdata_o   = iomem_rdata_i;
            end
            VERI: begin
                iomem_valid_o = 1'b1;
                iomem_addr_o  = l1v_addr_i;
                iomem_wdata_o = l1v_wdata_i;
                iomem_wstrb_o = l1v_wstrb_i;
                l1v_ready_o   = iomem_ready_i;
                l1v_rdata_o   = iomem_rdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_anabellek_hakem.sv
// Directed bench for anabellek_hakem: expected transactions are queued when a
// request is raised and popped when the arbiter puts one on the iomem port.
module tb_anabellek_hakem;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [18:2] l1b_addr_i = '0;
    logic        l1b_valid_i = 1'b0;
    logic [31:0] l1b_rdata_o;
    logic        l1b_ready_o;
    logic [18:2] l1v_addr_i = '0;
    logic        l1v_valid_i = 1'b0;
    logic [31:0] l1v_wdata_i = 32'd0;
    logic [3:0]  l1v_wstrb_i = 4'd0;
    logic [31:0] l1v_rdata_o;
    logic        l1v_ready_o;
    logic [18:2] iomem_addr_o;
    logic        iomem_valid_o;
    logic [31:0] iomem_wdata_o;
    logic [3:0]  iomem_wstrb_o;
    logic [31:0] iomem_rdata_i = 32'd0;
    logic        iomem_ready_i = 1'b0;
    logic        hata_o;

    anabellek_hakem #(.ONCELIK_BASLANGIC(1'b0), .BEKLEME_SINIRI(16'd5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .l1b_addr_i(l1b_addr_i), .l1b_valid_i(l1b_valid_i),
        .l1b_rdata_o(l1b_rdata_o), .l1b_ready_o(l1b_ready_o),
        .l1v_addr_i(l1v_addr_i), .l1v_valid_i(l1v_valid_i),
        .l1v_wdata_i(l1v_wdata_i), .l1v_wstrb_i(l1v_wstrb_i),
        .l1v_rdata_o(l1v_rdata_o), .l1v_ready_o(l1v_ready_o),
        .iomem_addr_o(iomem_addr_o), .iomem_valid_o(iomem_valid_o),
        .iomem_wdata_o(iomem_wdata_o), .iomem_wstrb_o(iomem_wstrb_o),
        .iomem_rdata_i(iomem_rdata_i), .iomem_ready_i(iomem_ready_i),
        .hata_o(hata_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_v;
        logic [16:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   last_wait = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic check_zero(input string tag);
        #1;
        chk(tag, {iomem_valid_o, iomem_addr_o, iomem_wdata_o, iomem_wstrb_o,
                  l1b_ready_o, l1v_ready_o, hata_o}, 64'd0);
        chk({tag, "_rdata"}, {l1b_rdata_o, l1v_rdata_o}, 64'd0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        check_zero("reset_outputs");
        rst_i = 1'b0;
    endtask

    task automatic push(input bit is_v, input logic [16:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb);
        txn_t t;
        t.is_v = is_v; t.addr = addr; t.wdata = wdata; t.wstrb = wstrb;
        exp_q.push_back(t);
    endtask

    // Wait (bounded) for a grant, then answer it with ready in cycle n.
    // hata_from: first granted cycle where hata_o must be 1 (0 = never).
    task automatic serve(input int n, input logic [31:0] rd, input bit drop, input int hata_from);
        txn_t t;
        int w;
        logic [31:0] cur_rd;
        w = 0;
        while (!iomem_valid_o && w < 20) begin
            tick();
            w++;
        end
        last_wait = w;
        if (!iomem_valid_o) begin
            chk("grant_timeout", 64'd0, 64'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 64'd0, 64'd1);
            return;
        end
        t = exp_q.pop_front();
        for (int k = 1; k <= n; k++) begin
            if (k == n) begin
                iomem_ready_i = 1'b1;
                cur_rd = rd;
            end else begin
                cur_rd = 32'h1111_0000 + 32'(k);
            end
            iomem_rdata_i = cur_rd;
            #1;
            chk("iomem_valid", iomem_valid_o, 64'd1);
            chk("iomem_addr", iomem_addr_o, t.addr);
            chk("iomem_wstrb", iomem_wstrb_o, t.wstrb);
            chk("iomem_wdata", iomem_wdata_o, t.wdata);
            chk("l1b_ready", l1b_ready_o, 64'(!t.is_v && k == n));
            chk("l1v_ready", l1v_ready_o, 64'(t.is_v && k == n));
            chk("l1b_rdata", l1b_rdata_o, t.is_v ? 32'd0 : cur_rd);
            chk("l1v_rdata", l1v_rdata_o, t.is_v ? cur_rd : 32'd0);
            chk("hata", hata_o, 64'(hata_from != 0 && k >= hata_from));
            tick();
            if (k == n) begin
                iomem_ready_i = 1'b0;
                iomem_rdata_i = 32'd0;
                if (drop) begin
                    if (t.is_v) l1v_valid_i = 1'b0;
                    else        l1b_valid_i = 1'b0;
                end
                #1;
                chk("gap_valid", iomem_valid_o, 64'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL tb_timeout simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        do_reset();

        // Lone L1B read, ready in third granted cycle
        l1b_addr_i = 17'h00123;
        l1b_valid_i = 1'b1;
        push(1'b0, 17'h00123, 32'd0, 4'd0);
        serve(3, 32'hDEADBEEF, 1'b1, 0);
        chk("lone_b_latency", last_wait, 64'd1);

        // Ready while idle must not reach either requester
        do_reset();
        iomem_ready_i = 1'b1;
        iomem_rdata_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("idle_ready_b", l1b_ready_o, 64'd0);
            chk("idle_ready_v", l1v_ready_o, 64'd0);
            chk("idle_valid", iomem_valid_o, 64'd0);
            chk("idle_rdata", {l1b_rdata_o, l1v_rdata_o}, 64'd0);
            tick();
        end
        iomem_ready_i = 1'b0;
        iomem_rdata_i = 32'd0;

        // Simultaneous requests from initial priority: L1V first, then L1B
        l1v_addr_i = 17'h00040; l1v_wdata_i = 32'hCAFEF00D; l1v_wstrb_i = 4'hF;
        l1b_addr_i = 17'h00010;
        l1v_valid_i = 1'b1;
        l1b_valid_i = 1'b1;
        push(1'b1, 17'h00040, 32'hCAFEF00D, 4'hF);
        push(1'b0, 17'h00010, 32'd0, 4'd0);
        serve(1, 32'h0000_00AA, 1'b1, 0);
        serve(2, 32'h0000_00BB, 1'b1, 0);
        chk("simul_gap", last_wait, 64'd1);

        // Continuous contention: V,B,V,B,V,B with one idle cycle between
        do_reset();
        l1v_addr_i = 17'h1F00F; l1v_wdata_i = 32'h0BADC0DE; l1v_wstrb_i = 4'b0101;
        l1b_addr_i = 17'h00777;
        l1v_valid_i = 1'b1;
        l1b_valid_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) push(1'b1, 17'h1F00F, 32'h0BADC0DE, 4'b0101);
            else            push(1'b0, 17'h00777, 32'd0, 4'd0);
        end
        for (int i = 0; i < 6; i++) begin
            serve(1, 32'hA000_0000 + 32'(i), (i >= 4), 0);
            chk("contention_gap", last_wait, 64'd1);
        end

        // A lone L1V completion hands priority to L1B
        do_reset();
        l1v_addr_i = 17'h00200; l1v_wdata_i = 32'd0; l1v_wstrb_i = 4'd0;
        l1v_valid_i = 1'b1;
        push(1'b1, 17'h00200, 32'd0, 4'd0);
        serve(1, 32'h1234_5678, 1'b1, 0);
        l1b_addr_i = 17'h00300;
        l1v_valid_i = 1'b1;
        l1b_valid_i = 1'b1;
        push(1'b0, 17'h00300, 32'd0, 4'd0);
        push(1'b1, 17'h00200, 32'd0, 4'd0);
        serve(1, 32'h0000_0B0B, 1'b1, 0);
        serve(1, 32'h0000_0C0C, 1'b1, 0);

        // Watchdog: limit 5, ready withheld for 10 granted cycles
        do_reset();
        l1v_addr_i = 17'h00055; l1v_wdata_i = 32'h5555_AAAA; l1v_wstrb_i = 4'b0011;
        l1v_valid_i = 1'b1;
        push(1'b1, 17'h00055, 32'h5555_AAAA, 4'b0011);
        serve(11, 32'h7777_7777, 1'b1, 7);
        chk("hata_sticky_gap", hata_o, 64'd1);
        tick();
        tick();
        chk("hata_sticky_idle", hata_o, 64'd1);
        do_reset();

        // Reset in the second cycle of an L1B grant, then re-grant
        l1b_addr_i = 17'h00ABC;
        l1b_valid_i = 1'b1;
        push(1'b0, 17'h00ABC, 32'd0, 4'd0);
        tick();
        #1;
        chk("midrst_grant1", iomem_valid_o, 64'd1);
        tick();
        #1;
        chk("midrst_grant2", iomem_valid_o, 64'd1);
        rst_i = 1'b1;
        tick();
        check_zero("midrst_zero");
        rst_i = 1'b0;
        tick();
        #1;
        chk("midrst_regrant", iomem_valid_o, 64'd1);
        serve(1, 32'hFEED_FACE, 1'b1, 0);
        chk("midrst_regrant_wait", last_wait, 64'd0);

        chk("scoreboard_drained", exp_q.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
